apb4_mem_slave: RTL and testbench

Parametrised APB4 completer that backs a word-addressed register-file memory, adding byte strobes, programmable wait states and error response to the plain APB link. It sits on the APB bus as the device under test behind the existing APB interface and agents, and it is the reference target for the memory testbench.

---
 rtl/apb4_mem_slave_if.sv | 31 +++
 rtl/apb4_mem_slave.sv | 156 +++++++++++++++
 tb/tb_apb4_mem_slave.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_mem_slave_if.sv
// APB4 completer-side bus bundle for apb4_mem_slave.
//
// Handshake: the requester drives psel=1, penable=0 for one setup cycle and
// then raises penable for the access phase, holding paddr/pwrite/pwdata/pstrb
// stable until it samples pready=1 at a rising pclk edge. The completer raises
// pready for exactly one cycle to end the transfer; prdata and pslverr are only
// meaningful in that cycle.
interface apb4_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 completer backing a word-addressed, byte-strobed register-file memory
// with a fixed number of wait states per transfer.
//
// Optional feature: define APB4_MEM_SLVERR_EN to report out-of-range accesses
// with pslverr=1 (reads then keep the previous prdata). Without it pslverr is
// tied low and out-of-range reads return zero. Out-of-range writes are always
// dropped.
module apb4_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             pclk,
    input  logic             presetn,
    apb4_mem_slave_if.slave  apb,
    output logic [1:0]       dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    // Counter value in the last WAIT cycle; unused when WAIT_STATES is 0.
    localparam logic [3:0] LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IDX_W-1:0]        idx;
    logic                    oor;
    logic                    setup;
    logic                    access;
    logic                    enter_done;
    logic                    wr_commit;
    logic                    pready_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    // Any set bit above the word index means the byte address is past the
    // end of the memory, so no wide compare against DEPTH*bytes is needed.
    assign word_addr = apb.paddr >> LSB;
    assign idx       = word_addr[IDX_W-1:0];
    assign oor       = |(word_addr >> IDX_W);

    assign setup      = apb.psel && !apb.penable;
    assign access     = apb.psel && apb.penable;
    assign enter_done = (state_nxt == S_DONE);
    assign wr_commit  = (state == S_DONE) && access && apb.pwrite && !oor;

    assign dbg_state  = state;
    assign apb.pready = pready_q;
    assign apb.prdata = prdata_q;

    // State and wait-counter registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: setup starts a transfer, access cycles count down the wait
    // states, and any drop of psel/penable mid-transfer abandons it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    cnt_nxt   = '0;
                    state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered response: pready for the DONE cycle only, read data captured
    // on the way into DONE so the output has no combinational input path.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            pready_q <= enter_done;
`ifdef APB4_MEM_SLVERR_EN
            if (enter_done && !apb.pwrite && !oor) begin
                prdata_q <= mem[idx];
            end
`else
            if (enter_done && !apb.pwrite) begin
                prdata_q <= oor ? '0 : mem[idx];
            end
`endif
        end
    end

`ifdef APB4_MEM_SLVERR_EN
    logic pslverr_q;

    // Error flag accompanies pready for out-of-range addresses.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= enter_done && oor;
        end
    end

    assign apb.pslverr = pslverr_q;
`else
    assign apb.pslverr = 1'b0;
`endif

    // Memory array: cleared on reset, byte lanes written in the DONE cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (apb.pstrb[b]) begin
                    mem[idx][b*8 +: 8] <= apb.pwdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three instances (0, 1 and 3 wait states) share one
// requester; psel is steered to the instance under test. Expected responses
// come from a byte-array memory model and are queued at issue time; a monitor
// pops and compares whenever the selected instance raises pready.
module tb_apb4_mem_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int NB    = DEPTH * (DW / 8);
    localparam int EW    = 65;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    int          sel     = 0;

    int unsigned cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    // Entry: {setup cycle[31:0], expected pslverr, expected prdata[31:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    logic [7:0]  mb [3][NB];
    logic [31:0] m_prdata [3];

    logic [1:0]  dbg0, dbg1, dbg2;
    logic        cur_pready, cur_pslverr;
    logic [31:0] cur_prdata;

    // Clock and cycle counter.
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    apb4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus0.psel = psel && (sel == 0);
    assign bus1.psel = psel && (sel == 1);
    assign bus2.psel = psel && (sel == 2);
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;
    assign bus0.pstrb = pstrb;
    assign bus1.pstrb = pstrb;
    assign bus2.pstrb = pstrb;

    apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .apb(bus0), .dbg_state(dbg0));
    apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
        .pclk(pclk), .presetn(presetn), .apb(bus1), .dbg_state(dbg1));
    apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (
        .pclk(pclk), .presetn(presetn), .apb(bus2), .dbg_state(dbg2));

    always_comb begin
        cur_pready  = bus2.pready;
        cur_pslverr = bus2.pslverr;
        cur_prdata  = bus2.prdata;
        case (sel)
            0: begin
                cur_pready  = bus0.pready;
                cur_pslverr = bus0.pslverr;
                cur_prdata  = bus0.prdata;
            end
            1: begin
                cur_pready  = bus1.pready;
                cur_pslverr = bus1.pslverr;
                cur_prdata  = bus1.prdata;
            end
            default: ;
        endcase
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string name, input logic rdy, input logic [31:0] rd,
                                    input logic err, input logic [1:0] st);
        check({name, "_pready"}, 32'(rdy), 32'd0);
        check({name, "_prdata"}, rd, 32'd0);
        check({name, "_pslverr"}, 32'(err), 32'd0);
        check({name, "_state"}, 32'(st), 32'd0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NB; i++) mb[d][i] = 8'h00;
            m_prdata[d] = 32'h0;
        end
    endtask

    // Scoreboard monitor: every pready must match the oldest queued transfer.
    always @(negedge pclk) begin
        if (presetn) begin
            if ((bus0.pready && sel != 0) || (bus1.pready && sel != 1) || (bus2.pready && sel != 2)) begin
                tests++;
                fails++;
                $display("FAIL idle_pready: unselected instance raised pready, sel=%0d", sel);
            end
            if (cur_pready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pready: instance %0d pready=1, expected no completion", sel);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc - mon_e[64:33], 32'(ws_of(sel) + 1));
                    check("pslverr", 32'(cur_pslverr), 32'(mon_e[32]));
                    check("prdata", cur_prdata, mon_e[31:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One complete transfer; called at posedge+1 so calls chain back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        bit          oor;
        int          base;
        logic [31:0] r;
        logic        err;
        bit          done;
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        oor  = (addr >= NB);
        base = int'(addr & 32'hFFFF_FFFC);
        if (wr) begin
            if (!oor)
                for (int i = 0; i < 4; i++)
                    if (strb[i]) mb[d][base + i] = data[8*i +: 8];
        end else begin
            if (!oor) begin
                for (int i = 0; i < 4; i++) r[8*i +: 8] = mb[d][base + i];
                m_prdata[d] = r;
            end else begin
`ifndef APB4_MEM_SLVERR_EN
                m_prdata[d] = 32'h0;
`endif
            end
        end
`ifdef APB4_MEM_SLVERR_EN
        err = oor;
`else
        err = 1'b0;
`endif
        exp_q.push_back({cyc, err, m_prdata[d]});
        @(posedge pclk); #1;
        penable = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (cur_pready) done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: instance %0d addr 0x%08h no pready within 40 cycles", d, addr);
            void'(exp_q.pop_back());
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check_reset_outs("rst0", bus0.pready, bus0.prdata, bus0.pslverr, dbg0);
        check_reset_outs("rst1", bus1.pready, bus1.prdata, bus1.pslverr, dbg1);
        check_reset_outs("rst2", bus2.pready, bus2.prdata, bus2.pslverr, dbg2);
        presetn = 1'b1;
        idle(2);

        // Full-word write and read back, one wait state.
        xfer(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1, 0, 32'h10, 32'h0, 4'h0);
        // Partial strobes merge into existing word.
        xfer(1, 1, 32'h20, 32'h11223344, 4'hF);
        xfer(1, 1, 32'h20, 32'hAABBCCDD, 4'h5);
        xfer(1, 0, 32'h20, 32'h0, 4'h0);
        xfer(1, 1, 32'h20, 32'h55555555, 4'h0);
        xfer(1, 0, 32'h20, 32'h0, 4'h0);
        // Zero wait states, back-to-back read/write/read.
        idle(1);
        xfer(0, 0, 32'h0, 32'h0, 4'h0);
        xfer(0, 1, 32'h4, 32'hCAFEF00D, 4'hF);
        xfer(0, 0, 32'h4, 32'h0, 4'h0);
        // Out of range: must not alias onto word 0.
        xfer(1, 1, 32'h0, 32'h0BADC0DE, 4'hF);
        xfer(1, 0, 32'h0, 32'h0, 4'h0);
        xfer(1, 1, 32'h400, 32'hFFFFFFFF, 4'hF);
        xfer(1, 0, 32'h400, 32'h0, 4'h0);
        xfer(1, 0, 32'h0, 32'h0, 4'h0);
        xfer(1, 0, 32'h3FC, 32'h0, 4'h0);
        xfer(2, 0, 32'hFFFF_FFFC, 32'h0, 4'h0);

        // Abort a write on the 3-wait-state instance by dropping penable.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8; pwdata = 32'h12345678; pstrb = 4'hF;
        idle(1);
        penable = 1'b1;
        idle(1);
        penable = 1'b0;
        idle(1);
        psel = 1'b0;
        idle(8);
        xfer(2, 0, 32'h8, 32'h0, 4'h0);

        // Randomised traffic across all instances.
        for (int n = 0; n < 300; n++) begin
            int          d;
            bit          wr;
            logic [31:0] a;
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 32'h400 + $urandom_range(0, 32'hFFFF);
                1:       a = $urandom_range(0, NB - 1);
                default: a = $urandom_range(0, 63);
            endcase
            xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Reset in the second WAIT cycle of a write loses the write.
        v = $urandom | 32'h1;
        xfer(2, 1, 32'hC, v, 4'hF);
        xfer(2, 0, 32'hC, 32'h0, 4'h0);
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h30; pwdata = v; pstrb = 4'hF;
        idle(1);
        penable = 1'b1;
        idle(1);
        presetn = 1'b0;
        #1;
        check_reset_outs("midrst2", bus2.pready, bus2.prdata, bus2.pslverr, dbg2);
        model_reset();
        psel = 1'b0; penable = 1'b0;
        idle(1);
        presetn = 1'b1;
        idle(2);
        xfer(2, 0, 32'h30, 32'h0, 4'h0);
        xfer(2, 0, 32'hC, 32'h0, 4'h0);
        xfer(1, 0, 32'h10, 32'h0, 4'h0);

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
